mic_channel_accumulator: RTL

Sequential summing stage that collects one signed PCM sample from each of NUM_CH microphone channels, sign-extends them to the 19-bit datapath, and accumulates them into a single 19-bit two's-complement frame sum with saturation and overflow flagging. It sits directly upstream of the 19-bit beam adder, feeding it one summed sample per frame over a valid/ready handshake. Samples arrive serially, one channel per accepted beat, in fixed channel order 0..NUM_CH-1.

---
 rtl/mic_channel_accumulator.sv | 86 ++++++++
 1 files changed

// File: rtl/mic_channel_accumulator.sv
// rtl/mic_channel_accumulator.sv - serial per-frame sum of NUM_CH signed mic samples with saturation
module mic_channel_accumulator #(
    parameter int NUM_CH = 8,
    parameter int IN_W   = 16,
    parameter int ACC_W  = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);
    localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    logic [CW-1:0]    ch_cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;

    logic             last_beat;
    logic             accept;
    logic [ACC_W-1:0] sext_in;
    logic [ACC_W:0]   sum;
    logic             beat_ovf;
    logic [ACC_W-1:0] sat_sum;

    assign last_beat = (ch_cnt == LAST_CH);
    // Only the frame-completing beat waits on a full output register.
    assign in_ready  = !clear && !(last_beat && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;

    assign sext_in  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign sum      = {acc[ACC_W-1], acc} + {sext_in[ACC_W-1], sext_in};
    // Sign bits of the one-bit-wider sum disagree exactly when ACC_W overflowed.
    assign beat_ovf = (sum[ACC_W] != sum[ACC_W-1]);

    always_comb begin
        sat_sum = sum[ACC_W-1:0];
        if (beat_ovf) begin
            sat_sum = sum[ACC_W] ? SAT_NEG : SAT_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (clear) begin
            ch_cnt  <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            if (ch_cnt == '0) begin
                acc     <= sext_in;
                ovf_acc <= 1'b0;
                ch_cnt  <= ch_cnt + 1'b1;
            end else begin
                acc     <= sat_sum;
                ovf_acc <= ovf_acc | beat_ovf;
                ch_cnt  <= last_beat ? '0 : ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept && last_beat) begin
            out_valid <= 1'b1;
            out_data  <= sat_sum;
            out_ovf   <= ovf_acc | beat_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
